// File: rtl/booth_seq_multiplier_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//   - FSM state encoding (IDLE/EXEC/DONE)
//   - default operand width
//   - Booth recoding actions and the decoder for the {lo[0], q_1} bit pair
package booth_seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_e;

  // Radix-2 Booth recoding: 01 ends a run of ones (add), 10 starts one (sub).
  function automatic booth_e booth_decode(input logic lo0, input logic q1);
    case ({lo0, q1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_multiplier_addsub.sv
// Combinational WIDTH+1-bit Booth add/sub/pass stage.
// Ports:
//   acc   - current sign-extended high partial product (WIDTH+1 bits)
//   mcand - latched signed multiplicand (WIDTH bits)
//   pair  - {lo[0], q_1} Booth bit pair
//   sum   - acc, acc+sext(mcand) or acc-sext(mcand)
// The extra bit keeps acc - (-2^(WIDTH-1)) from overflowing.
module booth_addsub
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic [1:0]       pair,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] ext;

  assign ext = {mcand[WIDTH-1], mcand};

  always_comb begin
    sum = acc;
    case (booth_decode(pair[1], pair[0]))
      BOOTH_ADD: sum = acc + ext;
      BOOTH_SUB: sum = acc - ext;
      default:   sum = acc;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH.
// One Booth step per clock; WIDTH steps always run (no early exit).
// Ports:
//   clk          - rising-edge clock
//   reset_n      - synchronous active-low reset
//   multiplier   - signed operand, sampled on the start edge only
//   multiplicand - signed operand, sampled on the start edge only
//   op_start     - level request to begin a multiply (taken in IDLE only)
//   op_clear     - synchronous clear of result/status/FSM; beats op_start
//   op_done      - high while result holds the final product
//   result       - {high, low} product; partial value while busy
module booth_seq_multiplier
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               op_start,
  input  logic               op_clear,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e             state, state_d;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   lo;
  logic               q_1;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum;

  logic load, step, clr, fin;

  booth_addsub #(.WIDTH(WIDTH)) u_addsub (
    .acc   (acc),
    .mcand (mcand),
    .pair  ({lo[0], q_1}),
    .sum   (sum)
  );

  // Next-state and datapath control
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    clr     = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        if (op_clear) begin
          clr = 1'b1;
        end else if (op_start) begin
          load    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op_clear) begin
          clr     = 1'b1;
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == LAST_STEP) begin
            fin     = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // op_start is ignored here: a new multiply needs a clear first.
        if (op_clear) begin
          clr     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc     <= '0;
      lo      <= '0;
      q_1     <= 1'b0;
      mcand   <= '0;
      cnt     <= '0;
      op_done <= 1'b0;
    end else if (clr) begin
      acc     <= '0;
      lo      <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      op_done <= 1'b0;
    end else if (load) begin
      mcand   <= multiplicand;
      acc     <= '0;
      lo      <= multiplier;
      q_1     <= 1'b0;
      cnt     <= '0;
      op_done <= 1'b0;
    end else if (step) begin
      // Arithmetic shift right of {sum, lo, q_1}; acc MSB replicates.
      acc <= {sum[WIDTH], sum[WIDTH:1]};
      lo  <= {sum[0], lo[WIDTH-1:1]};
      q_1 <= lo[0];
      cnt <= cnt + 1'b1;
      if (fin) op_done <= 1'b1;
    end
  end

  assign result = {acc[WIDTH-1:0], lo};

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier (WIDTH=64).
// Stimulus pushes expected products into a queue; a monitor pops one entry
// on every op_done rising edge and compares it to result.
module tb_booth_seq_multiplier;

  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   multiplicand;
  logic           op_start;
  logic           op_clear;
  logic           op_done;
  logic [2*W-1:0] result;

  int total = 0;
  int bad   = 0;
  int rises = 0;
  logic [2*W-1:0] exp_q[$];
  logic prev_done = 1'b0;

  booth_seq_multiplier #(.WIDTH(W), .CNT_W(7)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .op_done      (op_done),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (op_done === 1'b1 && prev_done !== 1'b1) begin
      rises++;
      check("done_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) check("result", result, exp_q.pop_front());
    end
    prev_done <= op_done;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge after the start edge; counts edges until op_done.
  task automatic wait_done(output int n);
    n = 0;
    while (op_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    multiplier   = a;
    multiplicand = b;
    op_start     = 1'b1;
    tick();
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input bit hold);
    int n;
    exp_q.push_back(exp);
    issue(a, b);
    if (!hold) op_start = 1'b0;
    wait_done(n);
    check("latency", 128'(n), 128'd64);
  endtask

  task automatic clear_pulse();
    op_clear = 1'b1;
    tick();
    op_clear = 1'b0;
  endtask

  initial begin
    int n;
    reset_n      = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    tick();
    tick();
    check("reset_result", result, '0);
    check("reset_done", 128'(op_done), 128'd0);
    reset_n = 1'b1;
    tick();

    // 5 x 6, then op_done/result must hold for 10 idle cycles
    run_op(64'd5, 64'd6, 128'd30, 1'b0);
    repeat (10) tick();
    check("hold_done", 128'(op_done), 128'd1);
    check("hold_result", result, 128'd30);
    clear_pulse();
    check("clear_result", result, '0);
    check("clear_done", 128'(op_done), 128'd0);

    // -3 x 7 = -21
    run_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB, 1'b0);
    clear_pulse();

    // (-2^63)^2 = 2^126
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
    clear_pulse();

    // op_start held through DONE: no restart; clear wins over start
    run_op(64'd10, 64'd10, 128'd100, 1'b1);
    repeat (5) tick();
    check("held_start_done", 128'(op_done), 128'd1);
    check("held_start_result", result, 128'd100);
    multiplier   = 64'd24;
    multiplicand = 64'd5;
    op_clear     = 1'b1;
    tick();
    check("clr_vs_start_result", result, '0);
    check("clr_vs_start_done", 128'(op_done), 128'd0);
    op_clear = 1'b0;
    exp_q.push_back(128'd120);
    tick();                        // start edge taken with op_start still high
    op_start = 1'b0;
    wait_done(n);
    check("restart_latency", 128'(n), 128'd64);
    clear_pulse();

    // Abort via op_clear mid-operation
    issue(64'd100, 64'd100);
    op_start = 1'b0;
    repeat (29) tick();
    check("mid_busy", 128'(op_done), 128'd0);
    clear_pulse();
    check("abort_clr_result", result, '0);
    check("abort_clr_done", 128'(op_done), 128'd0);
    run_op(64'd2, 64'd3, 128'd6, 1'b0);
    clear_pulse();

    // Abort via reset mid-operation
    issue(64'd100, 64'd100);
    op_start = 1'b0;
    repeat (29) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_rst_result", result, '0);
    check("abort_rst_done", 128'(op_done), 128'd0);
    run_op(64'd2, 64'd3, 128'd6, 1'b0);
    clear_pulse();

    // Operands scrambled during EXEC must not matter
    exp_q.push_back(128'd132);
    issue(64'd12, 64'd11);
    op_start = 1'b0;
    n = 0;
    while (op_done !== 1'b1 && n < 200) begin
      multiplier   = {$urandom, $urandom};
      multiplicand = {$urandom, $urandom};
      tick();
      n++;
    end
    check("scramble_latency", 128'(n), 128'd64);
    repeat (3) tick();

    check("queue_drained", 128'(exp_q.size()), 128'd0);
    check("done_rises", 128'(rises), 128'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
